atto_buffered_router: RTL and testbench

ATTO_BUFFERED_ROUTER -- requirements
Module: atto_buffered_router

---
 rtl/atto_buffered_router.sv | 206 ++++++++++++++++++++
 tb/tb_atto_buffered_router.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atto_buffered_router.sv
// Three-input (north/east/PE), three-output (south/west/PE) buffered XY router.
// Each input has a FIFO; each outport has one output register with round-robin arbitration.
module atto_buffered_router #(
    parameter int X_LOCAL    = 2,
    parameter int Y_LOCAL    = 2,
    parameter int COORD_W    = 4,
    parameter int DATA_W     = 48,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clka,
    input  logic                      rsta,
    input  logic [DATA_W-1:0]         north_din,
    input  logic                      north_din_valid,
    output logic                      north_din_ready,
    input  logic [DATA_W-1:0]         east_din,
    input  logic                      east_din_valid,
    output logic                      east_din_ready,
    input  logic [DATA_W-1:0]         pe_din,
    input  logic                      pe_din_valid,
    output logic                      pe_din_ready,
    output logic [DATA_W-1:0]         south_dout,
    output logic                      south_dout_valid,
    input  logic                      south_dout_ready,
    output logic [DATA_W-1:0]         west_dout,
    output logic                      west_dout_valid,
    input  logic                      west_dout_ready,
    output logic [DATA_W-2*COORD_W-1:0] pe_dout,
    output logic                      pe_dout_valid,
    input  logic                      pe_dout_ready
);

    localparam int PAY_W = DATA_W - 2*COORD_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int NPORT = 3;

    typedef enum logic [1:0] {
        OUT_WEST  = 2'd0,
        OUT_SOUTH = 2'd1,
        OUT_PE    = 2'd2
    } out_e;

    logic [DATA_W-1:0] din [NPORT];
    logic [NPORT-1:0]  din_valid;
    logic [NPORT-1:0]  din_ready;
    logic [NPORT-1:0]  push;
    logic [NPORT-1:0]  pop;
    logic [NPORT-1:0]  head_valid;
    logic [DATA_W-1:0] head [NPORT];
    out_e              route [NPORT];

    logic [DATA_W-1:0] mem_q [NPORT][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [NPORT];
    logic [PTR_W-1:0]  rd_ptr_d [NPORT];
    logic [PTR_W-1:0]  wr_ptr_q [NPORT];
    logic [PTR_W-1:0]  wr_ptr_d [NPORT];
    logic [CNT_W-1:0]  count_q [NPORT];
    logic [CNT_W-1:0]  count_d [NPORT];

    logic [NPORT-1:0]  dout_ready;
    logic [NPORT-1:0]  can_load;
    logic [NPORT-1:0]  gnt_any;
    logic [1:0]        win [NPORT];
    logic [1:0]        cand;
    logic [1:0]        rr_q [NPORT];
    logic [1:0]        rr_d [NPORT];
    logic [NPORT-1:0]  out_valid_q;
    logic [NPORT-1:0]  out_valid_d;
    logic [DATA_W-1:0] west_data_q;
    logic [DATA_W-1:0] west_data_d;
    logic [DATA_W-1:0] south_data_q;
    logic [DATA_W-1:0] south_data_d;
    logic [PAY_W-1:0]  pe_data_q;
    logic [PAY_W-1:0]  pe_data_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [1:0] rot3(input logic [1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        return 2'(s % 3);
    endfunction

    assign din[0]     = north_din;
    assign din[1]     = east_din;
    assign din[2]     = pe_din;
    assign din_valid  = {pe_din_valid, east_din_valid, north_din_valid};
    assign dout_ready = {pe_dout_ready, south_dout_ready, west_dout_ready};

    assign north_din_ready = din_ready[0];
    assign east_din_ready  = din_ready[1];
    assign pe_din_ready    = din_ready[2];

    assign west_dout        = west_data_q;
    assign south_dout       = south_data_q;
    assign pe_dout          = pe_data_q;
    assign west_dout_valid  = out_valid_q[OUT_WEST];
    assign south_dout_valid = out_valid_q[OUT_SOUTH];
    assign pe_dout_valid    = out_valid_q[OUT_PE];

    always_comb begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            din_ready[i]  = count_q[i] < CNT_W'(FIFO_DEPTH);
            head_valid[i] = count_q[i] != '0;
            head[i]       = mem_q[i][rd_ptr_q[i]];
            push[i]       = din_valid[i] & din_ready[i];
            if (head[i][DATA_W-1 -: COORD_W] != COORD_W'(X_LOCAL)) begin
                route[i] = OUT_WEST;
            end else if (head[i][DATA_W-1-COORD_W -: COORD_W] != COORD_W'(Y_LOCAL)) begin
                route[i] = OUT_SOUTH;
            end else begin
                route[i] = OUT_PE;
            end
        end
    end

    // Each head requests exactly one outport, so per-FIFO pops never exceed one.
    always_comb begin
        cand = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            can_load[o] = ~out_valid_q[o] | dout_ready[o];
            gnt_any[o]  = 1'b0;
            win[o]      = '0;
            rr_d[o]     = rr_q[o];
            for (int unsigned k = 0; k < NPORT; k++) begin
                cand = rot3(rr_q[o], k);
                if (can_load[o] && !gnt_any[o] && head_valid[cand] && route[cand] == out_e'(o)) begin
                    gnt_any[o] = 1'b1;
                    win[o]     = cand;
                end
            end
            if (gnt_any[o]) begin
                rr_d[o] = (win[o] == 2'd2) ? 2'd0 : win[o] + 2'd1;
            end
        end
        for (int unsigned i = 0; i < NPORT; i++) begin
            pop[i] = 1'b0;
            for (int unsigned o = 0; o < NPORT; o++) begin
                if (gnt_any[o] && win[o] == 2'(i)) begin
                    pop[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + 1'b1;
                2'b01:   count_d[i] = count_q[i] - 1'b1;
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_comb begin
        west_data_d  = west_data_q;
        south_data_d = south_data_q;
        pe_data_d    = pe_data_q;
        for (int unsigned o = 0; o < NPORT; o++) begin
            out_valid_d[o] = gnt_any[o] | (out_valid_q[o] & ~dout_ready[o]);
        end
        if (gnt_any[OUT_WEST])  west_data_d  = head[win[OUT_WEST]];
        if (gnt_any[OUT_SOUTH]) south_data_d = head[win[OUT_SOUTH]];
        if (gnt_any[OUT_PE])    pe_data_d    = head[win[OUT_PE]][PAY_W-1:0];
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                rr_q[i]     <= '0;
            end
            out_valid_q  <= '0;
            west_data_q  <= '0;
            south_data_q <= '0;
            pe_data_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
                rr_q[i]     <= rr_d[i];
            end
            out_valid_q  <= out_valid_d;
            west_data_q  <= west_data_d;
            south_data_q <= south_data_d;
            pe_data_q    <= pe_data_d;
        end
    end

    always_ff @(posedge clka) begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= din[i];
            end
        end
    end

endmodule

// File: tb/tb_atto_buffered_router.sv
// Self-checking bench for atto_buffered_router: directed scenarios plus a
// randomized run against a queue-based model of the routing and arbitration rules.
module tb_atto_buffered_router;

    localparam int DW = 48;
    localparam int PW = 40;
    localparam int D  = 4;

    logic          clka = 1'b0;
    logic          rsta = 1'b1;
    logic [DW-1:0] din [3];
    logic          dv [3];
    logic          dr [3];
    logic          ov [3];
    logic          ordy [3];
    logic [DW-1:0] south_dout;
    logic [DW-1:0] west_dout;
    logic [PW-1:0] pe_dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mq [3][$];
    logic          mv [3];
    logic [DW-1:0] md [3];
    int            rr [3];

    always #5 clka = ~clka;

    atto_buffered_router #(
        .X_LOCAL(2), .Y_LOCAL(2), .COORD_W(4), .DATA_W(DW), .FIFO_DEPTH(D)
    ) dut (
        .clka(clka), .rsta(rsta),
        .north_din(din[0]), .north_din_valid(dv[0]), .north_din_ready(dr[0]),
        .east_din(din[1]),  .east_din_valid(dv[1]),  .east_din_ready(dr[1]),
        .pe_din(din[2]),    .pe_din_valid(dv[2]),    .pe_din_ready(dr[2]),
        .south_dout(south_dout), .south_dout_valid(ov[1]), .south_dout_ready(ordy[1]),
        .west_dout(west_dout),   .west_dout_valid(ov[0]),  .west_dout_ready(ordy[0]),
        .pe_dout(pe_dout),       .pe_dout_valid(ov[2]),    .pe_dout_ready(ordy[2])
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Outport index: 0 west, 1 south, 2 PE.
    function automatic int route_of(input logic [DW-1:0] f);
        if (f[47:44] != 4'd2) return 0;
        if (f[43:40] != 4'd2) return 1;
        return 2;
    endfunction

    function automatic logic [DW-1:0] rand_flit();
        logic [3:0] dx, dy;
        dx = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd2;
        dy = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd2;
        return {dx, dy, 8'($urandom), 32'($urandom)};
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) begin
            dv[i]  = 1'b0;
            din[i] = '0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int i = 0; i < 3; i++) ordy[i] = 1'b1;
        #2 rsta = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL reset_dout_valid[%0d]: got %b want 0", i, ov[i]); end
            n_cmp++;
            if (dr[i] !== 1'b1) begin n_bad++; $display("FAIL reset_din_ready[%0d]: got %b want 1", i, dr[i]); end
        end
        n_cmp++;
        if (pe_dout !== '0) begin n_bad++; $display("FAIL reset_pe_dout: got %h want 0", pe_dout); end
        n_cmp++;
        if (west_dout !== '0 || south_dout !== '0) begin
            n_bad++; $display("FAIL reset_dout_data: got %h/%h want 0", west_dout, south_dout);
        end
        tick();
        tick();
        @(negedge clka) rsta = 1'b1;
        tick();
    endtask

    task automatic test_local();
        dv[0] = 1'b1; din[0] = 48'h22_00_0000_00AB;
        tick();
        dv[0] = 1'b0;
        n_cmp++;
        if (ov[2] !== 1'b0) begin n_bad++; $display("FAIL local_early: got valid %b want 0", ov[2]); end
        tick();
        n_cmp++;
        if (ov[2] !== 1'b1 || pe_dout !== 40'h00_0000_00AB) begin
            n_bad++; $display("FAIL local_deliver: got %b/%h want 1/00000000ab", ov[2], pe_dout);
        end
        tick();
        n_cmp++;
        if (ov[2] !== 1'b0) begin n_bad++; $display("FAIL local_one_cycle: got valid %b want 0", ov[2]); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp;
        for (int i = 0; i < 3; i++) begin dv[i] = 1'b1; din[i] = {8'h12, 32'h0, 4'd0, 4'(i)}; end
        tick();
        for (int i = 0; i < 3; i++) din[i] = {8'h12, 32'h0, 4'd1, 4'(i)};
        tick();
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            exp = {8'h12, 32'h0, 4'(k / 3), 4'(k % 3)};
            n_cmp++;
            if (ov[0] !== 1'b1 || west_dout !== exp) begin
                n_bad++; $display("FAIL rr_order[%0d]: got %b/%h want 1/%h", k, ov[0], west_dout, exp);
            end
            tick();
        end
        n_cmp++;
        if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL rr_drained: got valid %b want 0", ov[0]); end
    endtask

    task automatic test_backpressure();
        int  k;
        int  n_got;
        bit  acc;
        logic [DW-1:0] exp;
        k = 0;
        n_got = 0;
        ordy[1] = 1'b0;
        dv[1] = 1'b1; din[1] = {8'h21, 40'(100)};
        for (int c = 0; c < 8; c++) begin
            acc = dv[1] && dr[1];
            tick();
            if (acc) k++;
            dv[1] = (k < 6); din[1] = {8'h21, 40'(100 + k)};
        end
        n_cmp++;
        if (k !== 5) begin n_bad++; $display("FAIL bp_accepted: got %0d want 5", k); end
        n_cmp++;
        if (dr[1] !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", dr[1]); end
        n_cmp++;
        if (ov[1] !== 1'b1 || south_dout !== {8'h21, 40'(100)}) begin
            n_bad++; $display("FAIL bp_held: got %b/%h want 1/%h", ov[1], south_dout, {8'h21, 40'(100)});
        end
        ordy[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            acc = dv[1] && dr[1];
            if (ov[1]) begin
                exp = {8'h21, 40'(100 + n_got)};
                n_cmp++;
                if (south_dout !== exp) begin n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", n_got, south_dout, exp); end
                n_got++;
            end
            tick();
            if (acc) k++;
            dv[1] = (k < 6); din[1] = {8'h21, 40'(100 + k)};
        end
        n_cmp++;
        if (n_got !== 6 || k !== 6) begin n_bad++; $display("FAIL bp_totals: got %0d out/%0d in want 6/6", n_got, k); end
        idle_inputs();
    endtask

    task automatic test_hol();
        logic [DW-1:0] a1, a2, b, c;
        int n_s, n_w;
        a1 = {8'h21, 40'hA1}; a2 = {8'h21, 40'hA2};
        b  = {8'h12, 40'hB0}; c  = {8'h12, 40'hC0};
        n_s = 0; n_w = 0;
        ordy[0] = 1'b1; ordy[1] = 1'b0; ordy[2] = 1'b1;
        dv[0] = 1'b1; din[0] = a1; dv[1] = 1'b1; din[1] = c;
        tick();
        din[0] = a2; dv[1] = 1'b0;
        tick();
        n_cmp++;
        if (ov[0] !== 1'b1 || west_dout !== c) begin n_bad++; $display("FAIL hol_east_first: got %b/%h want 1/%h", ov[0], west_dout, c); end
        din[0] = b;
        tick();
        dv[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL hol_west_blocked[%0d]: got %b want 0", k, ov[0]); end
            n_cmp++;
            if (ov[1] !== 1'b1 || south_dout !== a1) begin n_bad++; $display("FAIL hol_south_hold[%0d]: got %b/%h want 1/%h", k, ov[1], south_dout, a1); end
            tick();
        end
        ordy[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (ov[1]) begin
                n_cmp++;
                if (south_dout !== ((n_s == 0) ? a1 : a2)) begin n_bad++; $display("FAIL hol_south_order[%0d]: got %h", n_s, south_dout); end
                n_s++;
            end
            if (ov[0]) begin
                n_cmp++;
                if (west_dout !== b) begin n_bad++; $display("FAIL hol_west_late: got %h want %h", west_dout, b); end
                n_w++;
            end
            tick();
        end
        n_cmp++;
        if (n_s !== 2 || n_w !== 1) begin n_bad++; $display("FAIL hol_totals: got %0d/%0d want 2/1", n_s, n_w); end
    endtask

    task automatic test_mid_reset();
        ordy[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dv[1] = 1'b1; din[1] = {8'h21, 40'(200 + k)};
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (ov[1] !== 1'b1) begin n_bad++; $display("FAIL mr_loaded: got %b want 1", ov[1]); end
        #2 rsta = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ov[i] !== 1'b0 || dr[i] !== 1'b1) begin
                n_bad++; $display("FAIL mr_async[%0d]: got valid %b ready %b want 0/1", i, ov[i], dr[i]);
            end
        end
        @(posedge clka);
        @(negedge clka) rsta = 1'b1;
        for (int i = 0; i < 3; i++) ordy[i] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL mr_no_output[%0d][%0d]: got %b want 0", k, i, ov[i]); end
            end
        end
    endtask

    task automatic model_step();
        bit acc [3];
        bit g [3];
        int w [3];
        int idx;
        for (int i = 0; i < 3; i++) acc[i] = dv[i] && (mq[i].size() < D);
        for (int o = 0; o < 3; o++) begin
            g[o] = 1'b0; w[o] = 0;
            if (!mv[o] || ordy[o]) begin
                for (int k = 0; k < 3; k++) begin
                    idx = (rr[o] + k) % 3;
                    if (!g[o] && mq[idx].size() > 0 && route_of(mq[idx][0]) == o) begin
                        g[o] = 1'b1; w[o] = idx;
                    end
                end
            end
        end
        for (int o = 0; o < 3; o++) begin
            if (g[o]) begin
                md[o] = mq[w[o]].pop_front();
                mv[o] = 1'b1;
                rr[o] = (w[o] + 1) % 3;
            end else if (ordy[o]) begin
                mv[o] = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back(din[i]);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < 3; i++) begin
            mq[i].delete(); mv[i] = 1'b0; md[i] = '0; rr[i] = 0;
        end
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 3; i++) begin
                dv[i]   = 1'($urandom_range(0, 1));
                din[i]  = rand_flit();
                ordy[i] = ($urandom_range(0, 3) != 0);
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (dr[i] !== (mq[i].size() < D)) begin
                    n_bad++; $display("FAIL rand_ready[%0d][%0d]: got %b want %b", c, i, dr[i], mq[i].size() < D);
                end
            end
            tick();
            model_step();
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ov[i] !== mv[i]) begin n_bad++; $display("FAIL rand_valid[%0d][%0d]: got %b want %b", c, i, ov[i], mv[i]); end
            end
            if (mv[0]) begin
                n_cmp++;
                if (west_dout !== md[0]) begin n_bad++; $display("FAIL rand_west[%0d]: got %h want %h", c, west_dout, md[0]); end
            end
            if (mv[1]) begin
                n_cmp++;
                if (south_dout !== md[1]) begin n_bad++; $display("FAIL rand_south[%0d]: got %h want %h", c, south_dout, md[1]); end
            end
            if (mv[2]) begin
                n_cmp++;
                if (pe_dout !== md[2][PW-1:0]) begin n_bad++; $display("FAIL rand_pe[%0d]: got %h want %h", c, pe_dout, md[2][PW-1:0]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < 3; i++) ordy[i] = 1'b1;
        test_reset();
        test_local();
        test_round_robin();
        test_backpressure();
        test_hol();
        test_mid_reset();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
